// File: rtl/scan_sequencer_pkg.sv
// rtl/scan_sequencer_pkg.sv - shared types and defaults for the scan sequencer
//
// Contents:
//   CNT_W_DEF / DATA_W_DEF / PIPE_LAT_DEF  default widths and pipeline depth
//   state_t                                sequencer state encoding (IDLE..DONE)
//   is_busy_state()                        states in which a scan is in flight
package scan_sequencer_pkg;

  localparam int CNT_W_DEF    = 8;
  localparam int DATA_W_DEF   = 16;
  localparam int PIPE_LAT_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SCAN  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic is_busy_state(input state_t s);
    return (s == ST_CLEAR) || (s == ST_SCAN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/scan_sequencer_if.sv
// rtl/scan_sequencer_if.sv - request/compare/result bundle of the scan sequencer
//
// Signals:
//   start, abort, length        scan request side (into sequencer)
//   count, sreset, max_in       comparator side (count/sreset out, max_in back in)
//   busy                        scan in flight
//   result, result_valid,
//   result_ack                  result handshake to the consumer
// Modports:
//   slave   the sequencer itself
//   master  the surrounding system (requester, comparator, consumer)
interface scan_sequencer_if #(
  parameter int CNT_W  = 8,
  parameter int DATA_W = 16
);

  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  length;
  logic [CNT_W-1:0]  count;
  logic              sreset;
  logic              busy;
  logic [DATA_W-1:0] max_in;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              result_ack;

  modport slave (
    input  start, abort, length, max_in, result_ack,
    output count, sreset, busy, result, result_valid
  );

  modport master (
    output start, abort, length, max_in, result_ack,
    input  count, sreset, busy, result, result_valid
  );

endinterface

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - drives the max-search comparator over a region and captures the result
//
// Ports:
//   mclk    system clock, all state on rising edge
//   reset   asynchronous active-low reset
//   bus     scan_sequencer_if.slave: start/abort/length request, count/sreset/max_in
//           comparator link, busy, result/result_valid/result_ack handshake
module scan_sequencer
  import scan_sequencer_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic            mclk,
  input  logic            reset,
  scan_sequencer_if.slave bus
);

  // Drain counter runs 0..PIPE_LAT-1.
  localparam int                DRN_W    = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE_LAT - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_count;
  logic              r_sreset;
  logic              r_busy;
  logic [DATA_W-1:0] r_result;
  logic              r_result_valid;
  logic [CNT_W-1:0]  r_len;
  logic [DRN_W-1:0]  r_drain;

  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              w_sreset_nxt;
  logic              w_busy_nxt;
  logic [DATA_W-1:0] w_result_nxt;
  logic              w_result_valid_nxt;
  logic [CNT_W-1:0]  w_len_nxt;
  logic [DRN_W-1:0]  w_drain_nxt;

  logic [CNT_W-1:0]  w_len_last;
  logic              w_in_flight;

  assign w_len_last  = r_len - 1'b1;
  assign w_in_flight = is_busy_state(r_state);

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_count        <= '0;
      r_sreset       <= 1'b0;
      r_busy         <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_len          <= '0;
      r_drain        <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_count        <= w_count_nxt;
      r_sreset       <= w_sreset_nxt;
      r_busy         <= w_busy_nxt;
      r_result       <= w_result_nxt;
      r_result_valid <= w_result_valid_nxt;
      r_len          <= w_len_nxt;
      r_drain        <= w_drain_nxt;
    end
  end

  // Every output is a register; this block computes the value each one takes
  // for the state being entered.
  always_comb begin
    w_state_nxt        = r_state;
    w_count_nxt        = r_count;
    w_sreset_nxt       = 1'b0;
    w_busy_nxt         = r_busy;
    w_result_nxt       = r_result;
    w_result_valid_nxt = r_result_valid;
    w_len_nxt          = r_len;
    w_drain_nxt        = r_drain;

    if (bus.abort && w_in_flight) begin
      // Abort wins over progression; the comparator is cleared so a partial
      // max cannot leak into the next scan.
      w_state_nxt  = ST_IDLE;
      w_sreset_nxt = 1'b1;
      w_count_nxt  = '0;
      w_drain_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_count_nxt = '0;
          if (bus.start) begin
            if (bus.length != '0) begin
              w_len_nxt    = bus.length;
              w_sreset_nxt = 1'b1;
              w_state_nxt  = ST_CLEAR;
            end else begin
              // Empty region: answer immediately without touching the comparator.
              w_result_nxt       = '0;
              w_result_valid_nxt = 1'b1;
              w_state_nxt        = ST_DONE;
            end
          end
        end

        ST_CLEAR: begin
          w_count_nxt = '0;
          w_state_nxt = ST_SCAN;
        end

        ST_SCAN: begin
          if (r_count == w_len_last) begin
            // Hold the last index while the pipeline drains; re-reading the
            // same word cannot change a maximum.
            w_drain_nxt = '0;
            w_state_nxt = ST_DRAIN;
          end else begin
            w_count_nxt = r_count + 1'b1;
          end
        end

        ST_DRAIN: begin
          if (r_drain == DRN_LAST) begin
            w_result_nxt       = bus.max_in;
            w_result_valid_nxt = 1'b1;
            w_count_nxt        = '0;
            w_drain_nxt        = '0;
            w_state_nxt        = ST_DONE;
          end else begin
            w_drain_nxt = r_drain + 1'b1;
          end
        end

        ST_DONE: begin
          if (bus.result_ack) begin
            w_result_valid_nxt = 1'b0;
            w_state_nxt        = ST_IDLE;
          end
        end

        default: begin
          w_state_nxt        = ST_IDLE;
          w_count_nxt        = '0;
          w_result_valid_nxt = 1'b0;
          w_drain_nxt        = '0;
        end
      endcase
    end

    w_busy_nxt = is_busy_state(w_state_nxt);
  end

  assign bus.count        = r_count;
  assign bus.sreset       = r_sreset;
  assign bus.busy         = r_busy;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - scoreboard bench for scan_sequencer with comparator and BRAM model
module tb_scan_sequencer;
  import scan_sequencer_pkg::*;

  localparam int CNT_W    = 8;
  localparam int DATA_W   = 16;
  localparam int PIPE_LAT = 3;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  logic mclk  = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t exp_q[$];

  always #5 mclk = ~mclk;
  always @(posedge mclk) cyc <= cyc + 1;

  scan_sequencer_if #(.CNT_W(CNT_W), .DATA_W(DATA_W)) bus();

  scan_sequencer #(.CNT_W(CNT_W), .DATA_W(DATA_W), .PIPE_LAT(PIPE_LAT)) dut (
    .mclk  (mclk),
    .reset (reset),
    .bus   (bus)
  );

  // Comparator + 256x16 BRAM: addra register, read latency 1, max register.
  logic [DATA_W-1:0] mem [256];
  logic [7:0]        startaddr = 8'd0;
  logic [7:0]        m_addra;
  logic [DATA_W-1:0] m_dout;
  logic [DATA_W-1:0] m_max;

  always @(posedge mclk or negedge reset) begin
    if (!reset) begin
      m_addra <= '0;
      m_dout  <= '0;
      m_max   <= '0;
    end else begin
      m_addra <= startaddr + bus.count;
      m_dout  <= mem[m_addra];
      m_max   <= bus.sreset ? '0 : ((m_dout > m_max) ? m_dout : m_max);
    end
  end
  assign bus.max_in = m_max;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_max(input int sa, input int len);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int k = 0; k < len; k++)
      if (mem[(sa + k) % 256] > m) m = mem[(sa + k) % 256];
    return m;
  endfunction

  // Result monitor: pops an expectation on every rising result_valid.
  logic [DATA_W-1:0] held;
  bit                prev_valid = 1'b0;
  always @(negedge mclk) begin
    exp_t e;
    if (!reset) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.result_valid && !prev_valid) begin
        check("valid_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("result", bus.result, e.data);
          check("result_cycle", cyc, e.cyc);
        end
        held = bus.result;
      end else if (bus.result_valid && prev_valid) begin
        check("result_hold", bus.result, held);
      end
      prev_valid = bus.result_valid;
    end
  end

  // One scan request. abort_i / spur_i index the cycle after acceptance
  // (0 = CLEAR) at which abort / a stray start is driven; -1 disables.
  task automatic scan(input int sa, input int len, input int abort_i, input int spur_i,
                      input int ack_wait, input bit coinc);
    int cs;
    int exp_cnt;
    @(negedge mclk);
    startaddr      = sa[7:0];
    bus.abort      = 1'($urandom_range(0, 1));
    bus.result_ack = 1'($urandom_range(0, 1));
    @(negedge mclk);
    bus.abort      = 1'b0;
    bus.result_ack = 1'b0;
    check("idle_sreset", bus.sreset, 0);
    check("idle_busy", bus.busy, 0);
    @(negedge mclk);
    cs = cyc;
    if (abort_i < 0)
      exp_q.push_back('{ref_max(sa, len), cs + 1 + ((len == 0) ? 0 : 1 + len + PIPE_LAT)});
    bus.start  = 1'b1;
    bus.length = CNT_W'(len);
    @(negedge mclk);
    bus.start = 1'b0;
    if (len == 0) begin
      check("len0_sreset", bus.sreset, 0);
      check("len0_count", bus.count, 0);
      check("len0_busy", bus.busy, 0);
    end else begin
      for (int i = 0; i <= len + PIPE_LAT; i++) begin
        if (i > 0) @(negedge mclk);
        exp_cnt = (i == 0) ? 0 : ((i <= len) ? i - 1 : len - 1);
        check("scan_sreset", bus.sreset, (i == 0) ? 1 : 0);
        check("scan_count", bus.count, exp_cnt);
        check("scan_busy", bus.busy, 1);
        bus.start      = (i == spur_i);
        bus.length     = (i == spur_i) ? CNT_W'(9) : CNT_W'(len);
        bus.result_ack = 1'($urandom_range(0, 1));
        bus.abort      = (i == abort_i);
        if (i == abort_i) begin
          @(negedge mclk);
          bus.abort      = 1'b0;
          bus.start      = 1'b0;
          bus.result_ack = 1'b0;
          check("abort_sreset", bus.sreset, 1);
          check("abort_count", bus.count, 0);
          check("abort_busy", bus.busy, 0);
          @(negedge mclk);
          check("abort_sreset_end", bus.sreset, 0);
          check("abort_idle", bus.busy, 0);
          return;
        end
      end
      @(negedge mclk);
      bus.start      = 1'b0;
      bus.result_ack = 1'b0;
      check("done_busy", bus.busy, 0);
    end
    check("done_valid", bus.result_valid, 1);
    for (int h = 0; h < ack_wait; h++) begin
      bus.abort  = 1'($urandom_range(0, 1));
      bus.start  = 1'($urandom_range(0, 1));
      bus.length = CNT_W'($urandom_range(0, 255));
      @(negedge mclk);
      check("hold_valid", bus.result_valid, 1);
      check("hold_busy", bus.busy, 0);
    end
    bus.abort      = 1'b0;
    bus.start      = coinc;
    bus.length     = CNT_W'(5);
    bus.result_ack = 1'b1;
    @(negedge mclk);
    bus.start      = 1'b0;
    bus.result_ack = 1'b0;
    check("ack_valid_drop", bus.result_valid, 0);
    check("ack_busy", bus.busy, 0);
    @(negedge mclk);
    check("ack_start_ignored", bus.busy, 0);
    check("ack_sreset", bus.sreset, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.length     = '0;
    bus.result_ack = 1'b0;
    for (int k = 0; k < 256; k++) mem[k] = DATA_W'($urandom);

    repeat (3) @(negedge mclk);
    check("rst_count", bus.count, 0);
    check("rst_sreset", bus.sreset, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_result", bus.result, 0);
    check("rst_valid", bus.result_valid, 0);
    reset = 1'b1;

    // Basic region with a known maximum, held 5 cycles before ack.
    mem[10] = 16'd7; mem[11] = 16'h1234; mem[12] = 16'd3; mem[13] = 16'h00FF;
    scan(10, 4, -1, -1, 5, 1'b0);

    // Reset in the middle of a scan.
    @(negedge mclk);
    startaddr = 8'd0;
    @(negedge mclk);
    bus.start = 1'b1; bus.length = CNT_W'(20);
    @(negedge mclk);
    bus.start = 1'b0;
    for (int t = 0; t < 40 && bus.count != 5; t++) @(negedge mclk);
    check("reach_count5", bus.count, 5);
    #2 reset = 1'b0;
    #1;
    check("midrst_count", bus.count, 0);
    check("midrst_sreset", bus.sreset, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_result", bus.result, 0);
    check("midrst_valid", bus.result_valid, 0);
    @(negedge mclk);
    reset = 1'b1;
    scan(30, 5, -1, -1, 1, 1'b0);

    // Empty region.
    scan(100, 0, -1, -1, 2, 1'b0);

    // Stray start with length 9 in SCAN.
    scan(20, 6, -1, 3, 0, 1'b0);

    // Abort at count=2 over large values, then single-word scans.
    mem[40] = 16'hFFF0; mem[41] = 16'hFFF1; mem[42] = 16'h0001;
    mem[43] = 16'h0002; mem[44] = 16'h0003; mem[45] = 16'h0004;
    scan(40, 6, 3, -1, 0, 1'b0);
    mem[60] = 16'hFFFF;
    scan(60, 1, -1, -1, 0, 1'b0);
    mem[70] = 16'h0001;
    scan(70, 1, -1, -1, 0, 1'b0);

    // Ack coincident with start in DONE.
    scan(80, 3, -1, -1, 0, 1'b1);

    // Randomized requests.
    for (int n = 0; n < 40; n++) begin
      int sa, len, ab, sp;
      mem[$urandom_range(0, 255)] = DATA_W'($urandom);
      sa = $urandom_range(0, 255);
      case ($urandom_range(0, 9))
        0:       len = 0;
        1:       len = $urandom_range(200, 255);
        default: len = $urandom_range(1, 16);
      endcase
      ab = (len > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, len + PIPE_LAT) : -1;
      sp = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len + PIPE_LAT) : -1;
      scan(sa, len, ab, sp, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge mclk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
